// File: rtl/fpu_issue_ctrl.sv
// COP1 issue sequencer: launches FPU ops, waits on long ops, writes back.
// Optional FPU_WDOG_EN adds a WAIT-state watchdog driving err.
module fpu_issue_ctrl #(
   parameter int unsigned LONG_OP_MAX = 2,
   parameter int unsigned WDOG_CYCLES = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [2:0]  op_code,
   input  logic        write_en,
   input  logic        flag_en,
   input  logic [4:0]  fd,
   output logic        fpu_start,
   output logic [2:0]  fpu_op,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result,
   input  logic        fpu_flag,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        cc_we,
   output logic        cc_data,
   output logic        stall,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WAIT,
      WB
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  fd_q, fd_d;
   logic        wen_q, wen_d;
   logic        fen_q, fen_d;
   logic        rf_we_q, rf_we_d;
   logic        cc_we_q, cc_we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ccd_q, ccd_d;
   logic        fin;
   logic        is_long;
   logic        err_d;

`ifdef FPU_WDOG_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   localparam logic [CNT_W-1:0] WdogLast = CNT_W'(WDOG_CYCLES - 1);
`endif

   assign is_long = 32'(op_q) < LONG_OP_MAX;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fd_d    = fd_q;
      wen_d   = wen_q;
      fen_d   = fen_q;
      rf_we_d = 1'b0;
      cc_we_d = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      ccd_d   = ccd_q;
      fin     = 1'b0;
      err_d   = 1'b0;
`ifdef FPU_WDOG_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            // Instructions with no architectural effect retire here
            if (issue_valid && (write_en || flag_en)) begin
               op_d    = op_code;
               fd_d    = fd;
               wen_d   = write_en;
               fen_d   = flag_en;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (is_long) begin
               state_d = WAIT;
`ifdef FPU_WDOG_EN
               cnt_d   = '0;
`endif
            end else begin
               fin = 1'b1;
            end
         end
         WAIT: begin
            if (fpu_done) begin
               fin = 1'b1;
`ifdef FPU_WDOG_EN
            end else if (cnt_q == WdogLast) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         state_d = WB;
         rf_we_d = wen_q;
         cc_we_d = fen_q;
         if (wen_q) begin
            waddr_d = fd_q;
            wdata_d = fpu_result;
         end
         if (fen_q) begin
            ccd_d = fpu_flag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         fd_q    <= '0;
         wen_q   <= 1'b0;
         fen_q   <= 1'b0;
         rf_we_q <= 1'b0;
         cc_we_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         ccd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fd_q    <= fd_d;
         wen_q   <= wen_d;
         fen_q   <= fen_d;
         rf_we_q <= rf_we_d;
         cc_we_q <= cc_we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         ccd_q   <= ccd_d;
      end
   end

`ifdef FPU_WDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
   assign err = err_d;
`else
   assign err = 1'b0;
`endif

   assign issue_ready = (state_q == IDLE);
   assign stall       = ~issue_ready;
   assign fpu_start   = (state_q == EXEC);
   assign fpu_op      = op_q;
   assign rf_we       = rf_we_q;
   assign rf_waddr    = waddr_q;
   assign rf_wdata    = wdata_q;
   assign cc_we       = cc_we_q;
   assign cc_data     = ccd_q;

endmodule
